// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related
// shared-peripheral logic.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE
  } arb_state_t;

  // Number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/TX-engine side bundle of the UART transmit arbiter.
// The master side is the environment (requesters and TX engine);
// the slave side is the arbiter itself.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
);
  localparam int ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_rdy;
  logic                      tx_load;
  logic [DATA_W-1:0]         tx_data;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      tmo_err;

  modport master (
    output req, req_data, tx_rdy,
    input  ack, tx_load, tx_data, grant_id, busy, tmo_err
  );

  modport slave (
    input  req, req_data, tx_rdy,
    output ack, tx_load, tx_data, grant_id, busy, tmo_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first set request at or above the pointer, wrapping
// back to 0. Purely combinational so it can front any shared resource.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               vld_o
);

  // Scan from the farthest offset down so the closest one to the pointer wins.
  always_comb begin
    int c;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr_i) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req_i[c]) begin
        idx_o = ID_W'(c);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX engine between NUM_REQ requesters.
// Each grant runs LOAD (tx_load + ack pulse), then waits for the engine to
// go busy (with timeout) and to come back ready.
// Optional build macro UART_ARB_LOCK_EN adds a per-requester 'lock' input that
// keeps re-granting the last winner so multi-byte packets stay contiguous.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = UART_DATA_W,
  parameter int BUSY_TMO = 64
) (
  input  logic               clk,
  input  logic               rst,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] lock,
`endif
  uart_tx_arbiter_if.slave   bus
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int CNT_W = clog2(BUSY_TMO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TMO - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_vld;
  logic              hold_lock;
  logic [ID_W-1:0]   sel_idx;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

`ifdef UART_ARB_LOCK_EN
  assign hold_lock = lock[grant_q] & bus.req[grant_q];
`else
  assign hold_lock = 1'b0;
`endif

  assign sel_idx = hold_lock ? grant_q : pick_idx;

  // State, pointer, grant and byte registers; all cleared by async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, then follow the engine handshake.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (bus.tx_rdy && (hold_lock || pick_vld)) begin
          grant_d = sel_idx;
          data_d  = bus.req_data[int'(sel_idx)*DATA_W +: DATA_W];
          state_d = LOAD;
          // A honoured lock leaves the rotation where it was.
          if (!hold_lock) begin
            ptr_d = (pick_idx == ID_LAST) ? '0 : pick_idx + ID_W'(1);
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!bus.tx_rdy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Engine never took the byte: flag it and drop the byte.
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.tx_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulses decode straight from state so reset kills them without a clock.
  assign bus.tx_load  = (state_q == LOAD);
  assign bus.ack      = (state_q == LOAD) ? (NUM_REQ'(1) << grant_q) : '0;
  assign bus.tx_data  = data_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.tmo_err  = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single grants, hand-written
// corner-case sequences, and a randomized run against a transaction-level
// round-robin model.
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

`ifdef UART_ARB_LOCK_EN
  logic [NR-1:0] lock;
`endif

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BUSY_TMO(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef UART_ARB_LOCK_EN
    .lock (lock),
`endif
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  bit eng_stuck = 1'b0;
  bit eng_abort = 1'b0;
  bit eng_hold  = 1'b0;
  bit eng_rand  = 1'b0;
  int eng_len   = 3;

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] data;
    int               exp_gid;
    logic [NR-1:0]    exp_ack;
    logic [DW-1:0]    exp_byte;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_load(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      ok = bus.tx_load;
    end
    chk("load_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      ok = !bus.busy && bus.tx_rdy;
    end
    chk("idle_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // TX engine model: goes busy one clock after a load, idles for a frame.
  initial begin
    bus.tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      bus.tx_rdy = !eng_hold;
      if (bus.tx_load && !eng_stuck && !rst) begin
        int len;
        len = eng_rand ? int'($urandom_range(1, 5)) : eng_len;
        @(posedge clk);
        #1 bus.tx_rdy = 1'b0;
        for (int k = 0; k < len && !eng_abort; k++) @(posedge clk);
        #1 bus.tx_rdy = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mptr;
    int loads;
    int waitc [NR];
    logic [NR-1:0]    preq;
    logic [NR*DW-1:0] pdata;

    tbl[0] = '{4'b0100, 32'h00A5_0000, 2, 4'b0100, 8'hA5};
    tbl[1] = '{4'b1001, 32'h3C00_00C3, 3, 4'b1000, 8'h3C};
    tbl[2] = '{4'b1001, 32'h1100_0022, 0, 4'b0001, 8'h22};
    tbl[3] = '{4'b0011, 32'h0000_4455, 1, 4'b0010, 8'h44};
    tbl[4] = '{4'b0011, 32'h0000_6677, 0, 4'b0001, 8'h77};
    tbl[5] = '{4'b1110, 32'h8899_AA00, 1, 4'b0010, 8'hAA};
    tbl[6] = '{4'b1000, 32'hBB00_0000, 3, 4'b1000, 8'hBB};
    tbl[7] = '{4'b0110, 32'h00CC_DD00, 1, 4'b0010, 8'hDD};

    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
`ifdef UART_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ack",     32'(bus.ack),      32'd0);
    chk("rst_tx_load", 32'(bus.tx_load),  32'd0);
    chk("rst_tx_data", 32'(bus.tx_data),  32'd0);
    chk("rst_grant",   32'(bus.grant_id), 32'd0);
    chk("rst_busy",    32'(bus.busy),     32'd0);
    chk("rst_tmo",     32'(bus.tmo_err),  32'd0);
    rst = 1'b0;

    // Single-grant table: pointer walks 0->3->0->1->2->1->2->0->2.
    for (int v = 0; v < 8; v++) begin
      wait_idle(60);
      bus.req      = tbl[v].req;
      bus.req_data = tbl[v].data;
      chk("tbl_preload", 32'(bus.tx_load), 32'd0);
      @(negedge clk);
      chk("tbl_latency", 32'(bus.tx_load),  32'd1);
      chk("tbl_ack",     32'(bus.ack),      32'(tbl[v].exp_ack));
      chk("tbl_gid",     32'(bus.grant_id), 32'(tbl[v].exp_gid));
      chk("tbl_byte",    32'(bus.tx_data),  32'(tbl[v].exp_byte));
      bus.req = '0;
    end

    // Engine not ready: a pending request must wait.
    wait_idle(60);
    eng_hold = 1'b1;
    repeat (2) @(negedge clk);
    bus.req = 4'b0001;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.tx_load || bus.busy) n++;
    end
    chk("hold_nogrant", 32'(n), 32'd0);
    eng_hold = 1'b0;
    wait_load(10);
    chk("hold_gid", 32'(bus.grant_id), 32'd0);
    bus.req = '0;

    // All four requesting with long frames: strict rotation, one idle gap.
    wait_idle(60);
    do_reset();
    eng_len = 10;
    bus.req_data = 32'h4342_4140;
    bus.req = 4'hF;
    wait_load(20);
    for (int k = 0; k < 5; k++) begin
      chk("rr_gid",  32'(bus.grant_id), 32'(k % 4));
      chk("rr_ack",  32'(bus.ack),      32'(1 << (k % 4)));
      chk("rr_byte", 32'(bus.tx_data),  32'(8'h40 + k % 4));
      if (k < 4) begin
        wait_idle(40);
        @(negedge clk);
        chk("rr_gap_load", 32'(bus.tx_load), 32'd1);
      end
    end
    bus.req = '0;
    eng_len = 3;

    // Wrap: grant 2 moves pointer to 3, then 3 and 0.
    wait_idle(60);
    bus.req_data = 32'hD3C2_00D0;
    bus.req = 4'b0100;
    wait_load(10);
    chk("wrap_g2", 32'(bus.grant_id), 32'd2);
    chk("wrap_b2", 32'(bus.tx_data),  32'hC2);
    bus.req = 4'b1001;
    wait_load(40);
    chk("wrap_g3", 32'(bus.grant_id), 32'd3);
    chk("wrap_b3", 32'(bus.tx_data),  32'hD3);
    wait_load(40);
    chk("wrap_g0", 32'(bus.grant_id), 32'd0);
    bus.req = '0;
    wait_idle(60);
    chk("data_hold", 32'(bus.tx_data), 32'hD0);

    // Engine never goes busy: timeout after TMO clocks in WAIT_START.
    eng_stuck = 1'b1;
    bus.req = 4'b0010;
    wait_load(10);
    chk("tmo_gid", 32'(bus.grant_id), 32'd1);
    bus.req = '0;
    chk("tmo_before", 32'(bus.tmo_err), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < TMO + 10);
    chk("tmo_len",   32'(n),           32'(TMO + 1));
    chk("tmo_after", 32'(bus.tmo_err), 32'd1);
    eng_stuck = 1'b0;
    bus.req = 4'b0100;
    wait_load(10);
    chk("tmo_next_gid", 32'(bus.grant_id), 32'd2);
    bus.req = '0;
    wait_idle(60);
    chk("tmo_sticky", 32'(bus.tmo_err), 32'd1);

    // Reset while the engine is mid-frame.
    eng_len = 20;
    bus.req = 4'b0010;
    wait_load(10);
    chk("rwd_gid", 32'(bus.grant_id), 32'd1);
    bus.req = '0;
    repeat (5) @(negedge clk);
    chk("rwd_busy_pre", 32'({bus.busy, bus.tx_rdy}), 32'b10);
    #2 rst = 1'b1;
    eng_abort = 1'b1;
    #1;
    chk("rwd_busy",    32'(bus.busy),     32'd0);
    chk("rwd_ack",     32'(bus.ack),      32'd0);
    chk("rwd_load",    32'(bus.tx_load),  32'd0);
    chk("rwd_tmo",     32'(bus.tmo_err),  32'd0);
    chk("rwd_gid_clr", 32'(bus.grant_id), 32'd0);
    repeat (2) @(negedge clk);
    eng_abort = 1'b0;
    eng_len = 3;
    rst = 1'b0;
    bus.req = 4'b1001;
    wait_load(10);
    chk("rwd_restart_gid", 32'(bus.grant_id), 32'd0);
    bus.req = '0;

    // Reset during the LOAD cycle kills the pulses at once.
    wait_idle(60);
    bus.req = 4'b0100;
    wait_load(10);
    #2 rst = 1'b1;
    eng_abort = 1'b1;
    #1;
    chk("rld_load", 32'(bus.tx_load), 32'd0);
    chk("rld_ack",  32'(bus.ack),     32'd0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    eng_abort = 1'b0;
    rst = 1'b0;

`ifdef UART_ARB_LOCK_EN
    // Locked requester 0 keeps the engine for three bytes.
    wait_idle(60);
    do_reset();
    lock = 4'b0001;
    bus.req_data = 32'h0000_1B1A;
    bus.req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      wait_load(40);
      chk("lock_gid", 32'(bus.grant_id), 32'd0);
    end
    lock = '0;
    wait_load(40);
    chk("lock_release_gid", 32'(bus.grant_id), 32'd1);
    bus.req = '0;
`endif

    // Randomized traffic against a transaction-level round-robin model.
    wait_idle(60);
    do_reset();
    eng_rand = 1'b1;
    mptr  = 0;
    loads = 0;
    preq  = '0;
    pdata = '0;
    for (int i = 0; i < NR; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (bus.tx_load) begin
        int w;
        int maxw;
        w = -1;
        for (int k = 0; k < NR; k++) begin
          if (w < 0 && preq[(mptr + k) % NR]) w = (mptr + k) % NR;
        end
        if (w < 0) begin
          chk("rand_spurious", 32'd1, 32'd0);
        end else begin
          chk("rand_gid",  32'(bus.grant_id), 32'(w));
          chk("rand_ack",  32'(bus.ack),      32'(1 << w));
          chk("rand_byte", 32'(bus.tx_data),  32'(pdata[w*DW +: DW]));
          maxw = 0;
          for (int i = 0; i < NR; i++) begin
            if (i == w) waitc[i] = 0;
            else if (preq[i]) waitc[i]++;
            if (waitc[i] > maxw) maxw = waitc[i];
          end
          chk("rand_starve", 32'(maxw <= NR - 1), 32'd1);
          mptr = (w + 1) % NR;
          loads++;
          if ($urandom_range(0, 1) == 1) bus.req_data[w*DW +: DW] = 8'($urandom);
          else bus.req[w] = 1'b0;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (!bus.req[i] && $urandom_range(0, 7) == 0) begin
          bus.req[i] = 1'b1;
          bus.req_data[i*DW +: DW] = 8'($urandom);
          waitc[i] = 0;
        end
      end
      preq  = bus.req;
      pdata = bus.req_data;
    end
    chk("rand_activity", 32'(loads > 100), 32'd1);
    bus.req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
